// File: rtl/splice_wr_arbiter.sv
// Round-robin write arbiter: splices one TILE_W-pixel line from one of four
// tile channels into a canvas-addressed burst (command, then TILE_W pixels).
module splice_wr_arbiter #(
   parameter logic [10:0] TILE_W    = 11'd320,
   parameter logic [9:0]  TILE_H    = 10'd180,
   parameter logic [10:0] CANVAS_W  = 11'd1280,
   parameter logic [17:0] BASE_ADDR = 18'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  ch_req,
   input  logic [3:0]  ch_vs,
   input  logic [63:0] ch_data,
   output logic [3:0]  ch_rd_en,
   output logic        wr_cmd_valid,
   input  logic        wr_cmd_ready,
   output logic [17:0] wr_cmd_addr,
   output logic [10:0] wr_cmd_len,
   output logic        wr_data_valid,
   input  logic        wr_data_ready,
   output logic [15:0] wr_data,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

   state_t      r_state;
   logic [3:0]  r_grant;
   logic [1:0]  r_g;
   logic [1:0]  r_ptr;
   logic [9:0]  r_line_cnt [4];
   logic [3:0]  r_pend;
   logic [10:0] r_pix;
   logic        r_cmd_valid;
   logic        r_data_valid;
   logic [17:0] r_addr;

   logic [1:0]  w_sel;
   logic [1:0]  w_idx;
   logic [9:0]  w_line;
   logic [17:0] w_addr;
   logic        w_accept;
   logic        w_last;

   // Lowest offset from the pointer wins, so scan offsets high to low.
   always_comb begin
      w_sel = r_ptr;
      w_idx = r_ptr;
      for (int k = 3; k >= 0; k--) begin
         w_idx = r_ptr + k[1:0];
         if (ch_req[w_idx]) w_sel = w_idx;
      end
   end

   // A frame start landing in the grant cycle already counts as line 0.
   assign w_line   = ch_vs[w_sel] ? 10'd0 : r_line_cnt[w_sel];
   assign w_addr   = BASE_ADDR
                   + ({8'd0, w_line} * {7'd0, CANVAS_W})
                   + ({16'd0, w_sel} * {7'd0, TILE_W});
   assign w_accept = r_data_valid & wr_data_ready;
   assign w_last   = (r_pix == TILE_W - 11'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_grant      <= '0;
         r_g          <= '0;
         r_ptr        <= '0;
         r_pend       <= '0;
         r_pix        <= '0;
         r_cmd_valid  <= 1'b0;
         r_data_valid <= 1'b0;
         r_addr       <= '0;
         for (int i = 0; i < 4; i++) r_line_cnt[i] <= '0;
      end else begin
         // The granted channel defers its clear to DONE so the burst keeps its address.
         for (int i = 0; i < 4; i++) begin
            if (ch_vs[i]) begin
               if (r_grant[i]) r_pend[i]       <= 1'b1;
               else            r_line_cnt[i]   <= '0;
            end
         end
         case (r_state)
            S_IDLE: begin
               if (|ch_req) begin
                  r_grant     <= 4'b0001 << w_sel;
                  r_g         <= w_sel;
                  r_addr      <= w_addr;
                  r_cmd_valid <= 1'b1;
                  r_state     <= S_CMD;
               end
            end
            S_CMD: begin
               if (wr_cmd_ready) begin
                  r_cmd_valid  <= 1'b0;
                  r_data_valid <= 1'b1;
                  r_state      <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  if (w_last) begin
                     r_pix        <= '0;
                     r_data_valid <= 1'b0;
                     r_state      <= S_DONE;
                  end else begin
                     r_pix <= r_pix + 11'd1;
                  end
               end
            end
            S_DONE: begin
               if (r_pend[r_g] || ch_vs[r_g])
                  r_line_cnt[r_g] <= '0;
               else if (r_line_cnt[r_g] == TILE_H - 10'd1)
                  r_line_cnt[r_g] <= '0;
               else
                  r_line_cnt[r_g] <= r_line_cnt[r_g] + 10'd1;
               r_pend[r_g] <= 1'b0;
               r_ptr       <= r_g + 2'd1;
               r_grant     <= '0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Pop is suppressed during reset so an aborted burst cannot steal a pixel.
   assign ch_rd_en      = (w_accept && !rst) ? r_grant : 4'b0000;
   assign wr_data       = r_data_valid ? ch_data[{r_g, 4'b0000} +: 16] : 16'h0000;
   assign wr_cmd_valid  = r_cmd_valid;
   assign wr_cmd_addr   = r_addr;
   assign wr_cmd_len    = TILE_W;
   assign wr_data_valid = r_data_valid;
   assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_splice_wr_arbiter.sv
// Bench for splice_wr_arbiter: infinite per-channel pixel sources, random
// handshakes, and a burst-level reference model of grants, addresses and line counts.
module tb_splice_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ch_req, ch_vs, ch_rd_en;
   logic [63:0] ch_data;
   logic        wr_cmd_valid, wr_cmd_ready, wr_data_valid, wr_data_ready, busy;
   logic [17:0] wr_cmd_addr;
   logic [10:0] wr_cmd_len;
   logic [15:0] wr_data;

   splice_wr_arbiter dut (
      .clk(clk), .rst(rst), .ch_req(ch_req), .ch_vs(ch_vs), .ch_data(ch_data),
      .ch_rd_en(ch_rd_en), .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
      .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len), .wr_data_valid(wr_data_valid),
      .wr_data_ready(wr_data_ready), .wr_data(wr_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp, n_fail;
   int p_cmd, p_dat;
   bit dr_tog, tog_ph, rnd_vs, chk_gap;
   logic [3:0] vs_drive;
   int pops[4], m_seq[4], m_line[4];
   bit m_pend[4];
   int m_ptr, m_g, m_acc, m_idle, m_pop0, bursts, exp_addr;
   bit m_active, m_cmd_acc, m_done;
   int addr_log[$];
   int chan_log[$];

   function automatic logic [15:0] pix(input int c, input int n);
      return 16'(((c & 3) << 14) | (n & 'h3fff));
   endfunction

   function automatic int pick(input logic [3:0] req, input int ptr);
      for (int k = 0; k < 4; k++) if (req[(ptr + k) % 4]) return (ptr + k) % 4;
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin m_line[i] = 0; m_pend[i] = 0; end
      m_ptr = 0; m_active = 0; m_cmd_acc = 0; m_done = 0; m_idle = 0; m_acc = 0;
   endtask

   task automatic step();
      bit fin;
      fin = 0;
      @(negedge clk);
      wr_cmd_ready = (int'($urandom_range(99)) < p_cmd);
      if (dr_tog) begin tog_ph = !tog_ph; wr_data_ready = tog_ph; end
      else wr_data_ready = (int'($urandom_range(99)) < p_dat);
      if (rnd_vs && m_active && m_cmd_acc && $urandom_range(99) == 0)
         vs_drive[$urandom_range(3)] = 1'b1;
      ch_vs = vs_drive;
      vs_drive = '0;
      for (int i = 0; i < 4; i++) ch_data[16*i +: 16] = pix(i, pops[i]);
      #1;
      if (rst) begin
         n_cmp++;
         if (ch_rd_en !== 4'b0000) begin n_fail++; $display("FAIL pop_in_reset: got %b want 0000", ch_rd_en); end
         model_reset();
         return;
      end
      for (int i = 0; i < 4; i++)
         if (ch_vs[i]) begin
            if (m_active && m_g == i) m_pend[i] = 1;
            else m_line[i] = 0;
         end
      if (m_done) begin
         n_cmp++;
         if (pops[m_g] - m_pop0 !== 320) begin n_fail++; $display("FAIL pops_per_burst: got %0d want 320", pops[m_g] - m_pop0); end
         m_line[m_g] = m_pend[m_g] ? 0 : (m_line[m_g] + 1) % 180;
         m_pend[m_g] = 0; m_ptr = (m_g + 1) % 4;
         m_active = 0; m_done = 0; m_cmd_acc = 0; fin = 1; bursts++;
      end
      n_cmp++;
      if (wr_data_valid !== (m_active && m_cmd_acc)) begin
         n_fail++; $display("FAIL data_valid: got %b want %b", wr_data_valid, m_active && m_cmd_acc);
      end
      if (wr_data_valid && wr_data_ready) begin
         n_cmp += 2;
         if (ch_rd_en !== (4'b0001 << m_g)) begin n_fail++; $display("FAIL rd_en: got %b want ch%0d", ch_rd_en, m_g); end
         if (wr_data !== pix(m_g, m_seq[m_g])) begin n_fail++; $display("FAIL wr_data: got %h want %h", wr_data, pix(m_g, m_seq[m_g])); end
         m_seq[m_g]++; m_acc++;
         if (m_acc == 320) m_done = 1;
      end else begin
         n_cmp++;
         if (ch_rd_en !== 4'b0000) begin n_fail++; $display("FAIL stray_pop: got %b want 0000", ch_rd_en); end
      end
      if (wr_cmd_valid && !m_active) begin
         m_g = pick(ch_req, m_ptr);
         n_cmp++;
         if (m_g < 0) begin n_fail++; $display("FAIL unexpected_cmd: got valid with req %b", ch_req); m_g = 0; end
         if (chk_gap && bursts > 0) begin
            n_cmp++;
            if (m_idle !== 2) begin n_fail++; $display("FAIL burst_gap: got %0d idle cycles want 2", m_idle); end
         end
         exp_addr = m_line[m_g] * 1280 + m_g * 320;
         m_active = 1; m_acc = 0; m_idle = 0; m_pop0 = pops[m_g];
         addr_log.push_back(int'(wr_cmd_addr)); chan_log.push_back(m_g);
      end
      if (m_active && !m_cmd_acc) begin
         n_cmp += 2;
         if (wr_cmd_valid !== 1'b1) begin n_fail++; $display("FAIL cmd_valid_drop: got %b want 1", wr_cmd_valid); end
         if (wr_cmd_addr !== 18'(exp_addr) || wr_cmd_len !== 11'd320) begin
            n_fail++; $display("FAIL cmd_addr_len: got %0d/%0d want %0d/320", wr_cmd_addr, wr_cmd_len, exp_addr);
         end
         if (wr_cmd_valid && wr_cmd_ready) m_cmd_acc = 1;
      end else begin
         n_cmp++;
         if (wr_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL cmd_valid: got %b want 0", wr_cmd_valid); end
      end
      n_cmp++;
      if (busy !== (m_active || fin)) begin n_fail++; $display("FAIL busy: got %b want %b", busy, m_active || fin); end
      for (int i = 0; i < 4; i++) if (ch_rd_en[i]) pops[i]++;
      if (!m_active) m_idle++;
   endtask

   task automatic do_reset();
      rst = 1'b1; ch_req = '0;
      step(); step();
      rst = 1'b0;
      model_reset();
      bursts = 0; tog_ph = 0;
      addr_log.delete(); chan_log.delete();
   endtask

   task automatic run_bursts(input int n, input int budget);
      int tgt, cyc;
      tgt = bursts + n; cyc = 0;
      while (bursts < tgt && cyc < budget) begin step(); cyc++; end
      n_cmp++;
      if (bursts < tgt) begin n_fail++; $display("FAIL burst_timeout: got %0d bursts want %0d", bursts, tgt); end
   endtask

   task automatic chk_log(input string nm, input int idx, input int want);
      n_cmp++;
      if (addr_log.size() <= idx) begin n_fail++; $display("FAIL %s: got no burst %0d want addr %0d", nm, idx, want); end
      else if (addr_log[idx] !== want) begin n_fail++; $display("FAIL %s: got addr %0d want %0d", nm, addr_log[idx], want); end
   endtask

   task automatic test_reset();
      do_reset();
      step();
      n_cmp++;
      if ({wr_cmd_valid, wr_data_valid, ch_rd_en, wr_cmd_addr, wr_data, busy} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got cv=%b dv=%b rd=%b addr=%0d data=%h busy=%b want all 0",
                             wr_cmd_valid, wr_data_valid, ch_rd_en, wr_cmd_addr, wr_data, busy);
      end
   endtask

   task automatic test_single();
      do_reset();
      ch_req = 4'b0100;
      run_bursts(2, 1000);
      n_cmp++;
      if (chan_log.size() < 1 || chan_log[0] !== 2) begin n_fail++; $display("FAIL single_grant: got %0d want 2", chan_log.size() ? chan_log[0] : -1); end
      chk_log("single_addr0", 0, 640);
      chk_log("single_addr1", 1, 1920);
   endtask

   task automatic test_round_robin();
      int ea[8] = '{0, 320, 640, 960, 1280, 1600, 1920, 2240};
      do_reset();
      ch_req = 4'b1111; chk_gap = 1;
      run_bursts(8, 4000);
      chk_gap = 0;
      for (int j = 0; j < 8; j++) begin
         chk_log("rr_addr", j, ea[j]);
         n_cmp++;
         if (chan_log.size() <= j || chan_log[j] !== j % 4) begin n_fail++; $display("FAIL rr_order: burst %0d want ch%0d", j, j % 4); end
      end
   endtask

   task automatic test_stall();
      int k;
      logic [17:0] a0;
      do_reset();
      ch_req = 4'b1000; p_cmd = 0; k = 0;
      while (!wr_cmd_valid && k < 10) begin step(); k++; end
      a0 = wr_cmd_addr;
      for (int j = 0; j < 9; j++) begin
         step();
         n_cmp++;
         if (wr_cmd_valid !== 1'b1 || wr_cmd_addr !== a0 || ch_rd_en !== 4'b0000) begin
            n_fail++; $display("FAIL cmd_stall: got cv=%b addr=%0d rd=%b want 1/%0d/0000", wr_cmd_valid, wr_cmd_addr, ch_rd_en, a0);
         end
      end
      p_cmd = 100; dr_tog = 1;
      run_bursts(1, 2000);
      dr_tog = 0;
      chk_log("stall_addr", 0, 960);
   endtask

   task automatic test_vs_mid();
      int k;
      do_reset();
      ch_req = 4'b0010;
      run_bursts(5, 2000);
      k = 0;
      while (!(m_active && m_acc >= 100) && k < 600) begin step(); k++; end
      vs_drive = 4'b0010;
      run_bursts(2, 2000);
      chk_log("vs_burst_addr", 5, 6720);
      chk_log("vs_next_addr", 6, 320);
   endtask

   task automatic test_wrap();
      do_reset();
      ch_req = 4'b0001;
      run_bursts(181, 181 * 330);
      chk_log("wrap_last_line", 179, 179 * 1280);
      chk_log("wrap_addr", 180, 0);
   endtask

   task automatic test_rst_mid();
      int k;
      ch_req = 4'b0001; k = 0;
      while (!(m_active && m_acc >= 50) && k < 700) begin step(); k++; end
      rst = 1'b1; ch_req = '0;
      step();
      rst = 1'b0;
      step();
      n_cmp++;
      if ({wr_cmd_valid, wr_data_valid, ch_rd_en, wr_cmd_addr, wr_data, busy} !== '0) begin
         n_fail++; $display("FAIL rst_mid_outputs: got cv=%b dv=%b rd=%b addr=%0d data=%h busy=%b want all 0",
                             wr_cmd_valid, wr_data_valid, ch_rd_en, wr_cmd_addr, wr_data, busy);
      end
      bursts = 0; addr_log.delete(); chan_log.delete();
      ch_req = 4'b0001;
      run_bursts(1, 1000);
      chk_log("rst_mid_next_addr", 0, 0);
   endtask

   task automatic test_random();
      do_reset();
      rnd_vs = 1;
      for (int r = 0; r < 4; r++) begin
         ch_req = 4'($urandom_range(1, 15));
         p_cmd  = $urandom_range(40, 100);
         p_dat  = $urandom_range(50, 100);
         run_bursts(3, 4000);
      end
      rnd_vs = 0; p_cmd = 100; p_dat = 100;
   endtask

   initial begin
      rst = 1'b1; ch_req = '0; ch_vs = '0; ch_data = '0; vs_drive = '0;
      wr_cmd_ready = 1'b0; wr_data_ready = 1'b0;
      n_cmp = 0; n_fail = 0; p_cmd = 100; p_dat = 100;
      dr_tog = 0; tog_ph = 0; rnd_vs = 0; chk_gap = 0; bursts = 0;
      for (int i = 0; i < 4; i++) begin pops[i] = 0; m_seq[i] = 0; end
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_vs_mid();
      test_wrap();
      test_rst_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
